data_memory: RTL and testbench

- Byte-addressed data RAM for the RV32I core's load/store path. It is reached through the `data_memory_if` interface bundle.
- Stores NUM_BLOCKS blocks of BLOCK_SIZE bits each.
- Performs full-word writes on the clock edge and combinational full-word reads starting at any byte address. Unaligned accesses and wrap-around past the top of memory are supported.

---
 rtl/data_memory_pkg.sv | 13 +
 rtl/rv32i_defs.sv | 9 +
 rtl/data_memory_if.sv | 48 ++++
 rtl/data_memory_lane_map.sv | 30 +++
 rtl/data_memory.sv | 71 +++++++
 tb/tb_data_memory.sv | 264 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/data_memory_pkg.sv
// Data-memory local definitions: default geometry and an index-width helper.
// Optional feature macro: DATA_MEMORY_BYTE_STROBE_EN (per-byte write strobes).
package data_memory_pkg;

  localparam int unsigned DmBlockSize = 8;
  localparam int unsigned DmNumBlocks = rv32i_defs::DataMemDepth;

  // Width of a block index; never zero, even for a one-block memory.
  function automatic int unsigned idx_width(input int unsigned num_blocks);
    return (num_blocks > 1) ? $clog2(num_blocks) : 1;
  endfunction

endpackage : data_memory_pkg

// File: rtl/rv32i_defs.sv
// Shared RV32I core definitions.
// OperandSize : architectural register/operand width in bits.
// DataMemDepth: default data-memory depth in bytes.
package rv32i_defs;

  localparam int unsigned OperandSize  = 32;
  localparam int unsigned DataMemDepth = 256;

endpackage : rv32i_defs

// File: rtl/data_memory_if.sv
// Load/store bus between the RV32I core and the data RAM.
// Ports       : clk (rising edge), rst (asynchronous, active-high).
// Signals     : addr (byte address of word LSB), write_enable, write_data, read_data.
// Optional    : write_strobe, one bit per byte lane, when DATA_MEMORY_BYTE_STROBE_EN is defined.
// Modports    : memory (RAM side), master (core side).
interface data_memory_if
  import data_memory_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = $clog2(DmNumBlocks),
  parameter int unsigned DATA_SIZE = rv32i_defs::OperandSize
) (
  input logic clk,
  input logic rst
);

  logic [ADDR_SIZE-1:0] addr;
  logic                 write_enable;
  logic [DATA_SIZE-1:0] write_data;
  logic [DATA_SIZE-1:0] read_data;
`ifdef DATA_MEMORY_BYTE_STROBE_EN
  logic [DATA_SIZE/DmBlockSize-1:0] write_strobe;
`endif

  modport memory (
    input  clk,
    input  rst,
    input  addr,
    input  write_enable,
    input  write_data,
`ifdef DATA_MEMORY_BYTE_STROBE_EN
    input  write_strobe,
`endif
    output read_data
  );

  modport master (
    input  clk,
    input  rst,
    output addr,
    output write_enable,
    output write_data,
`ifdef DATA_MEMORY_BYTE_STROBE_EN
    output write_strobe,
`endif
    input  read_data
  );

endinterface : data_memory_if

// File: rtl/data_memory_lane_map.sv
// Maps a byte address plus a fixed lane offset to a wrapped block index.
// Parameters: NUM_BLOCKS (memory depth), ADDR_SIZE (address width), IDX_SIZE (index width),
//             LANE (byte lane offset within the word).
// Ports     : addr (byte address of word LSB), idx (block index of this lane).
module data_memory_lane_map #(
  parameter int unsigned NUM_BLOCKS = 256,
  parameter int unsigned ADDR_SIZE  = 8,
  parameter int unsigned IDX_SIZE   = 8,
  parameter int unsigned LANE       = 0
) (
  input  logic [ADDR_SIZE-1:0] addr,
  output logic [IDX_SIZE-1:0]  idx
);

  localparam int unsigned LaneOffset = LANE % NUM_BLOCKS;

  logic [31:0] base;
  logic [31:0] sum;

  always_comb begin
    // Out-of-range addresses (non power-of-two depth) are folded first.
    base = 32'(addr) % NUM_BLOCKS;
    sum  = base + LaneOffset;
    if (sum >= NUM_BLOCKS) begin
      sum = sum - NUM_BLOCKS;
    end
    idx = IDX_SIZE'(sum);
  end

endmodule : data_memory_lane_map

// File: rtl/data_memory.sv
// Byte-addressed data RAM for the RV32I load/store path.
// Full-word clocked writes and combinational full-word reads from any byte address,
// little-endian, with wrap-around past the top of memory. rst clears all bytes at once.
// Parameters: BLOCK_SIZE (bits per byte block), NUM_BLOCKS (depth in blocks).
// Ports     : mem_if (data_memory_if, memory modport; carries clk and rst).
// Macro     : DATA_MEMORY_BYTE_STROBE_EN enables per-lane write_strobe gating.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = DmBlockSize,
  parameter int unsigned NUM_BLOCKS = DmNumBlocks
) (
  data_memory_if.memory mem_if
);

  localparam int unsigned DataSize   = $bits(mem_if.write_data);
  localparam int unsigned AddrSize   = $bits(mem_if.addr);
  localparam int unsigned WordBlocks = DataSize / BLOCK_SIZE;
  localparam int unsigned IdxSize    = idx_width(NUM_BLOCKS);

  logic [BLOCK_SIZE-1:0] mem_q [NUM_BLOCKS];
  logic [IdxSize-1:0]    lane_idx [WordBlocks];
  logic [WordBlocks-1:0] lane_we;
  logic [DataSize-1:0]   rdata;

  // Single port: the same lane index serves both the read and write paths.
  for (genvar k = 0; k < WordBlocks; k++) begin : g_lane
    data_memory_lane_map #(
      .NUM_BLOCKS (NUM_BLOCKS),
      .ADDR_SIZE  (AddrSize),
      .IDX_SIZE   (IdxSize),
      .LANE       (k)
    ) u_lane_map (
      .addr (mem_if.addr),
      .idx  (lane_idx[k])
    );
  end

  always_comb begin
    lane_we = '1;
`ifdef DATA_MEMORY_BYTE_STROBE_EN
    lane_we = mem_if.write_strobe;
`endif
  end

  // Reset is asynchronous so it beats a coincident write edge.
  always_ff @(posedge mem_if.clk or posedge mem_if.rst) begin
    if (mem_if.rst) begin
      for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_if.write_enable) begin
      for (int unsigned k = 0; k < WordBlocks; k++) begin
        if (lane_we[k]) begin
          mem_q[lane_idx[k]] <= mem_if.write_data[k*BLOCK_SIZE +: BLOCK_SIZE];
        end
      end
    end
  end

  // No write-through bypass: reads always show the stored contents.
  always_comb begin
    rdata = '0;
    for (int unsigned k = 0; k < WordBlocks; k++) begin
      rdata[k*BLOCK_SIZE +: BLOCK_SIZE] = mem_q[lane_idx[k]];
    end
  end

  assign mem_if.read_data = rdata;

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory.
module tb_data_memory;

  logic clk;
  logic rst;

  int n_cmp;
  int n_bad;

  localparam logic [31:0] Words [16] = '{
    32'h0123_4567, 32'h89AB_CDEF, 32'hDEAD_BEEF, 32'hCAFE_F00D,
    32'h1357_9BDF, 32'h2468_ACE0, 32'hFFFF_0000, 32'h0000_FFFF,
    32'hA5A5_5A5A, 32'h5A5A_A5A5, 32'h8000_0001, 32'h7FFF_FFFE,
    32'h0F1E_2D3C, 32'h4B5A_6978, 32'h8796_A5B4, 32'hC3D2_E1F0
  };

  data_memory_if #(.ADDR_SIZE(8), .DATA_SIZE(32)) mem_if (.clk(clk), .rst(rst));

  data_memory #(.BLOCK_SIZE(8), .NUM_BLOCKS(256)) dut (.mem_if(mem_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] strb);
    @(negedge clk);
    mem_if.addr         = a;
    mem_if.write_data   = d;
    mem_if.write_enable = 1'b1;
`ifdef DATA_MEMORY_BYTE_STROBE_EN
    mem_if.write_strobe = strb;
`else
    if (strb != 4'hF) $display("note: strobe %h ignored in this build", strb);
`endif
    @(posedge clk);
    #1;
    mem_if.write_enable = 1'b0;
`ifdef DATA_MEMORY_BYTE_STROBE_EN
    mem_if.write_strobe = 4'hF;
`endif
  endtask

  task automatic test_reset();
    logic [7:0] a_list [3];
    a_list = '{8'h00, 8'h10, 8'hFF};
    for (int i = 0; i < 3; i++) begin
      mem_if.addr = a_list[i];
      #1;
      n_cmp++;
      if (mem_if.read_data !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_clear addr=%h got=%h want=%h", a_list[i], mem_if.read_data, 32'h0);
      end
    end
    do_write(8'h10, 32'hDEAD_BEEF, 4'hF);
    mem_if.addr = 8'h10;
    #1;
    n_cmp++;
    if (mem_if.read_data !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL reset_prewrite got=%h want=%h", mem_if.read_data, 32'hDEAD_BEEF);
    end
    // Assert rst between edges: contents must clear without a clock edge.
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (mem_if.read_data !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_async got=%h want=%h", mem_if.read_data, 32'h0);
    end
    // Write edge while rst is held must be ignored.
    @(negedge clk);
    mem_if.addr         = 8'h10;
    mem_if.write_data   = 32'hCAFE_F00D;
    mem_if.write_enable = 1'b1;
    @(posedge clk);
    #1;
    mem_if.write_enable = 1'b0;
    n_cmp++;
    if (mem_if.read_data !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_blocks_write got=%h want=%h", mem_if.read_data, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (mem_if.read_data !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_release got=%h want=%h", mem_if.read_data, 32'h0);
    end
  endtask

  task automatic test_aligned_sweep();
    for (int i = 0; i < 16; i++) begin
      do_write(8'(8'h40 + 4 * i), Words[i], 4'hF);
    end
    for (int i = 0; i < 16; i++) begin
      mem_if.addr = 8'(8'h40 + 4 * i);
      #1;
      n_cmp++;
      if (mem_if.read_data !== Words[i]) begin
        n_bad++;
        $display("FAIL aligned_sweep addr=%h got=%h want=%h", mem_if.addr, mem_if.read_data,
                 Words[i]);
      end
    end
  endtask

  task automatic test_unaligned();
    logic [7:0]  a_list [4];
    logic [31:0] e_list [4];
    a_list = '{8'h05, 8'h04, 8'h08, 8'h02};
    e_list = '{32'h1122_3344, 32'h2233_4400, 32'h0000_0011, 32'h4400_0000};
    do_write(8'h05, 32'h1122_3344, 4'hF);
    for (int i = 0; i < 4; i++) begin
      mem_if.addr = a_list[i];
      #1;
      n_cmp++;
      if (mem_if.read_data !== e_list[i]) begin
        n_bad++;
        $display("FAIL unaligned addr=%h got=%h want=%h", a_list[i], mem_if.read_data, e_list[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0]  a_list [4];
    logic [31:0] e_list [4];
    a_list = '{8'hFE, 8'h00, 8'hFF, 8'hFD};
    e_list = '{32'hA1B2_C3D4, 32'h0000_A1B2, 32'h00A1_B2C3, 32'hB2C3_D400};
    do_write(8'hFE, 32'hA1B2_C3D4, 4'hF);
    for (int i = 0; i < 4; i++) begin
      mem_if.addr = a_list[i];
      #1;
      n_cmp++;
      if (mem_if.read_data !== e_list[i]) begin
        n_bad++;
        $display("FAIL wrap addr=%h got=%h want=%h", a_list[i], mem_if.read_data, e_list[i]);
      end
    end
  endtask

  task automatic test_start_sweep();
    logic [7:0] start;
    start = 8'hE2;
    for (int i = 0; i < 16; i++) begin
      do_write(8'(start + 4 * i), Words[i] ^ 32'h5A5A_A5A5, 4'hF);
    end
    for (int i = 0; i < 16; i++) begin
      mem_if.addr = 8'(start + 4 * i);
      #1;
      n_cmp++;
      if (mem_if.read_data !== (Words[i] ^ 32'h5A5A_A5A5)) begin
        n_bad++;
        $display("FAIL start_sweep addr=%h got=%h want=%h", mem_if.addr, mem_if.read_data,
                 Words[i] ^ 32'h5A5A_A5A5);
      end
    end
  endtask

  task automatic test_overlap();
    do_write(8'hA0, 32'hAAAA_AAAA, 4'hF);
    do_write(8'hA4, 32'hBBBB_BBBB, 4'hF);
    do_write(8'hA1, 32'h5566_7788, 4'hF);
    mem_if.addr = 8'hA0;
    #1;
    n_cmp++;
    if (mem_if.read_data !== 32'h6677_88AA) begin
      n_bad++;
      $display("FAIL overlap_low got=%h want=%h", mem_if.read_data, 32'h6677_88AA);
    end
    mem_if.addr = 8'hA4;
    #1;
    n_cmp++;
    if (mem_if.read_data !== 32'hBBBB_BB55) begin
      n_bad++;
      $display("FAIL overlap_high got=%h want=%h", mem_if.read_data, 32'hBBBB_BB55);
    end
  endtask

  task automatic test_no_bypass();
    @(negedge clk);
    mem_if.addr         = 8'hC0;
    mem_if.write_data   = 32'h1234_5678;
    mem_if.write_enable = 1'b1;
    #1;
    n_cmp++;
    if (mem_if.read_data !== 32'h0) begin
      n_bad++;
      $display("FAIL no_bypass_before got=%h want=%h", mem_if.read_data, 32'h0);
    end
    @(posedge clk);
    #1;
    mem_if.write_enable = 1'b0;
    n_cmp++;
    if (mem_if.read_data !== 32'h1234_5678) begin
      n_bad++;
      $display("FAIL no_bypass_after got=%h want=%h", mem_if.read_data, 32'h1234_5678);
    end
    // Back-to-back writes to consecutive words, one per cycle.
    @(negedge clk);
    mem_if.write_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_if.addr       = 8'(8'hD0 + 4 * i);
      mem_if.write_data = Words[i + 4];
      @(negedge clk);
    end
    mem_if.write_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_if.addr = 8'(8'hD0 + 4 * i);
      #1;
      n_cmp++;
      if (mem_if.read_data !== Words[i + 4]) begin
        n_bad++;
        $display("FAIL back_to_back addr=%h got=%h want=%h", mem_if.addr, mem_if.read_data,
                 Words[i + 4]);
      end
    end
  endtask

`ifdef DATA_MEMORY_BYTE_STROBE_EN
  task automatic test_strobe();
    do_write(8'h20, 32'hFFFF_FFFF, 4'hF);
    do_write(8'h20, 32'h0000_0000, 4'b0101);
    mem_if.addr = 8'h20;
    #1;
    n_cmp++;
    if (mem_if.read_data !== 32'hFF00_FF00) begin
      n_bad++;
      $display("FAIL strobe got=%h want=%h", mem_if.read_data, 32'hFF00_FF00);
    end
  endtask
`endif

  initial begin
    n_cmp               = 0;
    n_bad               = 0;
    rst                 = 1'b1;
    mem_if.addr         = '0;
    mem_if.write_enable = 1'b0;
    mem_if.write_data   = '0;
`ifdef DATA_MEMORY_BYTE_STROBE_EN
    mem_if.write_strobe = 4'hF;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    test_reset();
    test_aligned_sweep();
    test_unaligned();
    test_wrap();
    test_start_sweep();
    test_overlap();
    test_no_bypass();
`ifdef DATA_MEMORY_BYTE_STROBE_EN
    test_strobe();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_data_memory
